// File: rtl/spi_pkg.sv
// Shared constants, FSM states and frame layout for the SPI register-file slave.
package spi_pkg;

   localparam int unsigned ADDR_W     = 7;
   localparam int unsigned DATA_W     = 8;
   localparam int unsigned FRAME_BITS = 16;
   localparam int unsigned CNT_W      = $clog2(FRAME_BITS) + 1;

   localparam logic [ADDR_W-1:0] ADDR_EN_OUT_7_0  = 7'h00;
   localparam logic [ADDR_W-1:0] ADDR_EN_OUT_15_8 = 7'h01;
   localparam logic [ADDR_W-1:0] ADDR_EN_PWM_7_0  = 7'h02;
   localparam logic [ADDR_W-1:0] ADDR_EN_PWM_15_8 = 7'h03;
   localparam logic [ADDR_W-1:0] ADDR_PWM_DUTY    = 7'h04;
   localparam logic [ADDR_W-1:0] ADDR_MAX         = 7'h04;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   typedef struct packed {
      logic              rw;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } frame_t;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchroniser for an asynchronous pin followed by an edge-detect flop.
module spi_sync #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic        RESET_VAL   = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= {SYNC_STAGES{RESET_VAL}};
         r_prev <= RESET_VAL;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], din};
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   assign level = r_sync[SYNC_STAGES-1];
   assign rise  = level & ~r_prev;
   assign fall  = ~level & r_prev;

endmodule

// File: rtl/spi_peripheral.sv
// SPI mode-0 write-only slave driving the five PWM control registers.
// All SPI pins are synchronised into clk; nothing is clocked by SCLK.
module spi_peripheral
   import spi_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sclk,
   input  logic              copi,
   input  logic              ncs,
   output logic [DATA_W-1:0] en_reg_out_7_0,
   output logic [DATA_W-1:0] en_reg_out_15_8,
   output logic [DATA_W-1:0] en_reg_pwm_7_0,
   output logic [DATA_W-1:0] en_reg_pwm_15_8,
   output logic [DATA_W-1:0] pwm_duty_cycle
);

   logic w_sclk_level, w_sclk_rise, w_sclk_fall;
   logic w_copi_level, w_copi_rise, w_copi_fall;
   logic w_ncs_level, w_ncs_rise, w_ncs_fall;
   logic w_unused;

   spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
      .clk(clk), .rst_n(rst_n), .din(sclk),
      .level(w_sclk_level), .rise(w_sclk_rise), .fall(w_sclk_fall));

   spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
      .clk(clk), .rst_n(rst_n), .din(copi),
      .level(w_copi_level), .rise(w_copi_rise), .fall(w_copi_fall));

   spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
      .clk(clk), .rst_n(rst_n), .din(ncs),
      .level(w_ncs_level), .rise(w_ncs_rise), .fall(w_ncs_fall));

   assign w_unused = ^{w_sclk_level, w_sclk_fall, w_copi_rise, w_copi_fall};

   state_t                r_state, w_state_nxt;
   logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
   logic [FRAME_BITS-1:0] r_shift, w_shift_nxt;
   logic                  r_overflow, w_overflow_nxt;
   logic                  w_commit;
   logic                  w_sclk_act;
   frame_t                w_frame;

   assign w_frame    = r_shift;
   assign w_sclk_act = w_sclk_rise & ~w_ncs_level;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_shift    <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_shift    <= w_shift_nxt;
         r_overflow <= w_overflow_nxt;
      end
   end

   // nCS rise outranks any same-cycle SCLK rise, so that edge is never counted.
   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_shift_nxt    = r_shift;
      w_overflow_nxt = r_overflow;
      w_commit       = 1'b0;
      if (w_ncs_rise) begin
         w_state_nxt = IDLE;
         w_commit    = (r_state == DONE) && !r_overflow && w_frame.rw &&
                       (w_frame.addr <= ADDR_MAX);
      end else begin
         case (r_state)
            IDLE: begin
               if (w_ncs_fall) begin
                  w_state_nxt    = SHIFT;
                  w_cnt_nxt      = '0;
                  w_shift_nxt    = '0;
                  w_overflow_nxt = 1'b0;
               end
            end
            SHIFT: begin
               if (w_sclk_act) begin
                  w_shift_nxt = {r_shift[FRAME_BITS-2:0], w_copi_level};
                  w_cnt_nxt   = r_cnt + CNT_W'(1);
                  if (r_cnt == CNT_W'(FRAME_BITS - 1)) begin
                     w_state_nxt = DONE;
                  end
               end
            end
            DONE: begin
               if (w_sclk_act) begin
                  w_overflow_nxt = 1'b1;
               end
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_reg_out_7_0  <= '0;
         en_reg_out_15_8 <= '0;
         en_reg_pwm_7_0  <= '0;
         en_reg_pwm_15_8 <= '0;
         pwm_duty_cycle  <= '0;
      end else if (w_commit) begin
         case (w_frame.addr)
            ADDR_EN_OUT_7_0:  en_reg_out_7_0  <= w_frame.data;
            ADDR_EN_OUT_15_8: en_reg_out_15_8 <= w_frame.data;
            ADDR_EN_PWM_7_0:  en_reg_pwm_7_0  <= w_frame.data;
            ADDR_EN_PWM_15_8: en_reg_pwm_15_8 <= w_frame.data;
            ADDR_PWM_DUTY:    pwm_duty_cycle  <= w_frame.data;
            default: ;
         endcase
      end
   end

endmodule
